pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RV32I pipeline. It generates the stall, flush and PC-write controls consumed by the IF/ID and ID/EX pipeline registers and by the PC register, covering load-use hazards, taken branches/jumps resolved in EX, and instruction-memory wait cycles. A 2-state FSM tracks a redirect that arrives while a fetch is still outstanding. Saturating event counters expose hazard statistics for benchmarking.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 7 +
 rtl/hz_sat_counter.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared encodings for the hazard controller
package pipeline_hazard_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_DISCARD = 1'b1} state_t;
  localparam logic PC_SEL_PLUS4 = 1'b0;
  localparam logic PC_SEL_TARGET = 1'b1;
  localparam logic [1:0] MEM_NONE = 2'b00;
endpackage

// File: rtl/hz_sat_counter.sv
// hz_sat_counter: saturating event counter, clear wins over increment
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/PC control for the 5-stage RV32I pipeline,
// with a DISCARD state covering a redirect that lands while a fetch is outstanding
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IMEM_VALID,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE_RS1_ID,
  input  logic             USE_RS2_ID,
  input  logic [4:0]       RD_DE,
  input  logic [1:0]       MemRead_DE,
  input  logic             BR_TAKEN_E,
  input  logic [XLEN-1:0]  BR_TARGET_E,
  input  logic             CLR_CNT,
  output logic             flush_FD,
  output logic             flush_DE,
  output logic             stall_FD,
  output logic             stall_DE,
  output logic             PC_WE,
  output logic             PC_SEL,
  output logic [XLEN-1:0]  PC_TARGET,
  output logic [CNT_W-1:0] CNT_LDUSE,
  output logic [CNT_W-1:0] CNT_FLUSH,
  output logic [CNT_W-1:0] CNT_FWAIT
);
  state_t state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic load_use, inc_ldu, inc_fl, inc_fw;
  assign load_use = (MemRead_DE != MEM_NONE) && (RD_DE != 5'd0) &&
                    ((USE_RS1_ID && RS1_ID == RD_DE) || (USE_RS2_ID && RS2_ID == RD_DE));
  assign stall_DE = 1'b0;
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    flush_FD  = 1'b0;
    flush_DE  = 1'b0;
    stall_FD  = 1'b0;
    PC_WE     = 1'b0;
    PC_SEL    = PC_SEL_PLUS4;
    PC_TARGET = '0;
    inc_ldu   = 1'b0;
    inc_fl    = 1'b0;
    inc_fw    = 1'b0;
    if (!RST) begin
      if (state_q == ST_DISCARD) begin
        flush_FD  = 1'b1;
        PC_SEL    = PC_SEL_TARGET;
        PC_TARGET = tgt_q;
        PC_WE     = IMEM_VALID;
        inc_fw    = !IMEM_VALID;
        state_d   = IMEM_VALID ? ST_RUN : ST_DISCARD;
      end else if (BR_TAKEN_E) begin
        // younger instructions die, so a coincident load-use is moot
        flush_FD  = 1'b1;
        flush_DE  = 1'b1;
        PC_SEL    = PC_SEL_TARGET;
        PC_TARGET = BR_TARGET_E;
        PC_WE     = IMEM_VALID;
        inc_fl    = 1'b1;
        state_d   = IMEM_VALID ? ST_RUN : ST_DISCARD;
        tgt_d     = IMEM_VALID ? tgt_q : BR_TARGET_E;
      end else if (load_use) begin
        stall_FD  = 1'b1;
        flush_DE  = 1'b1;
        PC_TARGET = BR_TARGET_E;
        inc_ldu   = 1'b1;
      end else begin
        flush_FD  = !IMEM_VALID;
        PC_WE     = IMEM_VALID;
        PC_TARGET = BR_TARGET_E;
        inc_fw    = !IMEM_VALID;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  hz_sat_counter #(.W(CNT_W)) u_cnt_ldu (.CLK(CLK), .RST(RST), .clr(CLR_CNT), .inc(inc_ldu), .cnt(CNT_LDUSE));
  hz_sat_counter #(.W(CNT_W)) u_cnt_fl  (.CLK(CLK), .RST(RST), .clr(CLR_CNT), .inc(inc_fl),  .cnt(CNT_FLUSH));
  hz_sat_counter #(.W(CNT_W)) u_cnt_fw  (.CLK(CLK), .RST(RST), .clr(CLR_CNT), .inc(inc_fw),  .cnt(CNT_FWAIT));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus random checks against a behavioural model,
// with a 4-bit-counter copy of the design to exercise saturation
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  logic        IMEM_VALID, USE_RS1_ID, USE_RS2_ID, BR_TAKEN_E, CLR_CNT;
  logic [4:0]  RS1_ID, RS2_ID, RD_DE;
  logic [1:0]  MemRead_DE;
  logic [31:0] BR_TARGET_E;
  logic        flush_FD, flush_DE, stall_FD, stall_DE, PC_WE, PC_SEL;
  logic [31:0] PC_TARGET, CNT_LDUSE, CNT_FLUSH, CNT_FWAIT;
  logic        f4_ffd, f4_fde, f4_sfd, f4_sde, f4_we, f4_sel;
  logic [31:0] f4_tgt;
  logic [3:0]  c4_ldu, c4_fl, c4_fw;
  pipeline_hazard_ctrl #(.CNT_W(32), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .IMEM_VALID(IMEM_VALID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID), .RD_DE(RD_DE), .MemRead_DE(MemRead_DE),
    .BR_TAKEN_E(BR_TAKEN_E), .BR_TARGET_E(BR_TARGET_E), .CLR_CNT(CLR_CNT),
    .flush_FD(flush_FD), .flush_DE(flush_DE), .stall_FD(stall_FD), .stall_DE(stall_DE),
    .PC_WE(PC_WE), .PC_SEL(PC_SEL), .PC_TARGET(PC_TARGET),
    .CNT_LDUSE(CNT_LDUSE), .CNT_FLUSH(CNT_FLUSH), .CNT_FWAIT(CNT_FWAIT));
  pipeline_hazard_ctrl #(.CNT_W(4), .XLEN(32)) dut4 (
    .CLK(CLK), .RST(RST), .IMEM_VALID(IMEM_VALID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID), .RD_DE(RD_DE), .MemRead_DE(MemRead_DE),
    .BR_TAKEN_E(BR_TAKEN_E), .BR_TARGET_E(BR_TARGET_E), .CLR_CNT(CLR_CNT),
    .flush_FD(f4_ffd), .flush_DE(f4_fde), .stall_FD(f4_sfd), .stall_DE(f4_sde),
    .PC_WE(f4_we), .PC_SEL(f4_sel), .PC_TARGET(f4_tgt),
    .CNT_LDUSE(c4_ldu), .CNT_FLUSH(c4_fl), .CNT_FWAIT(c4_fw));
  int total = 0;
  int bad = 0;
  bit m_disc;
  logic [31:0] m_tgt;
  int m_ldu, m_fl, m_fw;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit lu();
    return MemRead_DE != 2'b00 && RD_DE != 5'd0 &&
           ((USE_RS1_ID && RS1_ID == RD_DE) || (USE_RS2_ID && RS2_ID == RD_DE));
  endfunction
  function automatic int sat4(input int v);
    return v > 15 ? 15 : v;
  endfunction
  task automatic model_reset();
    m_disc = 0; m_tgt = '0; m_ldu = 0; m_fl = 0; m_fw = 0;
  endtask
  task automatic idle();
    IMEM_VALID = 1; RS1_ID = 0; RS2_ID = 0; USE_RS1_ID = 0; USE_RS2_ID = 0;
    RD_DE = 0; MemRead_DE = 0; BR_TAKEN_E = 0; BR_TARGET_E = 0; CLR_CNT = 0;
  endtask
  task automatic check_outs();
    logic effd, efde, esfd, ewe, esel, tchk;
    logic [31:0] etgt;
    effd = 0; efde = 0; esfd = 0; ewe = 0; esel = 0; tchk = 0; etgt = '0;
    if (RST) tchk = 1;
    else if (m_disc) begin
      effd = 1; ewe = IMEM_VALID; esel = 1; etgt = m_tgt; tchk = 1;
    end else if (BR_TAKEN_E) begin
      effd = 1; efde = 1; ewe = IMEM_VALID; esel = 1; etgt = BR_TARGET_E; tchk = IMEM_VALID;
    end else if (lu()) begin
      esfd = 1; efde = 1;
    end else if (!IMEM_VALID) effd = 1;
    else ewe = 1;
    chk("flush_FD", flush_FD, effd);
    chk("flush_DE", flush_DE, efde);
    chk("stall_FD", stall_FD, esfd);
    chk("stall_DE", stall_DE, 0);
    chk("PC_WE", PC_WE, ewe);
    if (ewe || RST) chk("PC_SEL", PC_SEL, esel);
    if (tchk) chk("PC_TARGET", PC_TARGET, etgt);
  endtask
  task automatic check_cnts();
    chk("CNT_LDUSE", CNT_LDUSE, m_ldu);
    chk("CNT_FLUSH", CNT_FLUSH, m_fl);
    chk("CNT_FWAIT", CNT_FWAIT, m_fw);
    chk("CNT4_LDUSE", c4_ldu, sat4(m_ldu));
    chk("CNT4_FLUSH", c4_fl, sat4(m_fl));
    chk("CNT4_FWAIT", c4_fw, sat4(m_fw));
  endtask
  task automatic update_model();
    if (m_disc) begin
      if (IMEM_VALID) m_disc = 0;
      else m_fw++;
    end else if (BR_TAKEN_E) begin
      m_fl++;
      if (!IMEM_VALID) begin
        m_disc = 1; m_tgt = BR_TARGET_E;
      end
    end else if (lu()) m_ldu++;
    else if (!IMEM_VALID) m_fw++;
    if (CLR_CNT) begin
      m_ldu = 0; m_fl = 0; m_fw = 0;
    end
  endtask
  task automatic step();
    #1 check_outs();
    @(posedge CLK);
    #1 update_model();
    check_cnts();
    @(negedge CLK);
  endtask
  initial begin
    idle();
    model_reset();
    @(negedge CLK);
    #1 check_outs();
    check_cnts();
    RST = 0;
    @(negedge CLK);
    idle(); MemRead_DE = 2'b10; RD_DE = 5; RS1_ID = 5; USE_RS1_ID = 1;
    step();
    chk("ldu_one", CNT_LDUSE, 1);
    idle();
    step();
    idle(); MemRead_DE = 2'b10; RD_DE = 0; RS1_ID = 0; USE_RS1_ID = 1;
    step();
    idle(); MemRead_DE = 2'b10; RD_DE = 7; RS2_ID = 7; USE_RS2_ID = 0;
    step();
    chk("no_false_stall", CNT_LDUSE, 1);
    idle(); BR_TAKEN_E = 1; BR_TARGET_E = 32'h100;
    #1 chk("br_tgt", PC_TARGET, 32'h100);
    step();
    chk("br_cnt", CNT_FLUSH, 1);
    idle(); BR_TAKEN_E = 1; BR_TARGET_E = 32'h200; IMEM_VALID = 0;
    step();
    BR_TAKEN_E = 0; BR_TARGET_E = 32'hdead;
    step();
    step();
    IMEM_VALID = 1;
    #1 chk("disc_tgt", PC_TARGET, 32'h200);
    chk("disc_we", PC_WE, 1);
    step();
    chk("fwait_disc", CNT_FWAIT, 2);
    idle();
    step();
    idle(); BR_TAKEN_E = 1; BR_TARGET_E = 32'h300; MemRead_DE = 2'b01; RD_DE = 3; RS1_ID = 3; USE_RS1_ID = 1;
    step();
    chk("br_over_ldu", CNT_LDUSE, 1);
    idle(); BR_TAKEN_E = 1; BR_TARGET_E = 32'h400; IMEM_VALID = 0;
    step();
    idle(); IMEM_VALID = 0;
    #2 RST = 1;
    model_reset();
    #1 check_outs();
    check_cnts();
    chk("rst_flush_FD", flush_FD, 0);
    @(negedge CLK);
    RST = 0;
    IMEM_VALID = 1;
    step();
    idle(); CLR_CNT = 1;
    step();
    idle(); MemRead_DE = 2'b10; RD_DE = 5; RS1_ID = 5; USE_RS1_ID = 1;
    repeat (20) step();
    chk("sat4_ldu", c4_ldu, 15);
    chk("ldu20", CNT_LDUSE, 20);
    CLR_CNT = 1;
    step();
    chk("clr_ldu", c4_ldu, 0);
    repeat (2000) begin
      IMEM_VALID  = $urandom_range(2) != 0;
      RS1_ID      = 5'($urandom_range(3));
      RS2_ID      = 5'($urandom_range(3));
      USE_RS1_ID  = 1'($urandom);
      USE_RS2_ID  = 1'($urandom);
      RD_DE       = 5'($urandom_range(3));
      MemRead_DE  = 2'($urandom);
      BR_TAKEN_E  = $urandom_range(5) == 0;
      BR_TARGET_E = $urandom & 32'hffff_fffc;
      CLR_CNT     = $urandom_range(49) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
